div_unit: RTL and testbench

Iterative 32-bit integer divider implementing the RV32M division group: DIV, DIVU, REM, REMU. It is the inverse counterpart to the ALU's single-cycle multiply path (MUL/MULH/MULHU). It sits beside the ALU in the execute stage and uses a start/busy/done handshake, so the core stalls while `busy` is high. The datapath is a radix-2 restoring divider on operand magnitudes, with sign correction applied on the final cycle.

---
 rtl/div_unit.sv | 121 ++++++++++++
 tb/tb_div_unit.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// Works on operand magnitudes; sign correction is applied in the FIX state.
module div_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic        done,
  output logic [31:0] result
);

  typedef enum logic [1:0] {StIdle, StCalc, StFix, StDone} state_e;

  state_e      state_q, state_d;
  logic        is_rem_q, is_rem_d;
  logic        neg_quo_q, neg_quo_d;
  logic        neg_rem_q, neg_rem_d;
  logic [31:0] quo_q, quo_d;
  logic [31:0] dvs_q, dvs_d;
  logic [31:0] rem_q, rem_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] result_q, result_d;

  logic        sgn;
  logic [31:0] a_mag, b_mag;
  logic        div_zero, ovf;
  logic [32:0] rem_sh;
  logic [31:0] diff;
  logic        ge;

  assign sgn      = ~op[0];
  assign a_mag    = (sgn && A[31]) ? (~A + 32'd1) : A;
  assign b_mag    = (sgn && B[31]) ? (~B + 32'd1) : B;
  assign div_zero = (B == 32'd0);
  assign ovf      = sgn && (A == 32'h8000_0000) && (B == 32'hFFFF_FFFF);

  // Partial remainder stays below |B| <= 2^32, so 33 bits after the shift suffice.
  assign rem_sh = {rem_q, quo_q[31]};
  assign ge     = (rem_sh >= {1'b0, dvs_q});
  assign diff   = rem_sh[31:0] - dvs_q;

  always_comb begin
    state_d   = state_q;
    is_rem_d  = is_rem_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    quo_d     = quo_q;
    dvs_d     = dvs_q;
    rem_d     = rem_q;
    cnt_d     = cnt_q;
    result_d  = result_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          is_rem_d = op[1];
          cnt_d    = 5'd31;
          dvs_d    = b_mag;
          if (div_zero || ovf) begin
            // Preload the final quotient/remainder so FIX emits them unmodified.
            quo_d     = div_zero ? 32'hFFFF_FFFF : 32'h8000_0000;
            rem_d     = div_zero ? A : 32'd0;
            neg_quo_d = 1'b0;
            neg_rem_d = 1'b0;
            state_d   = StFix;
          end else begin
            quo_d     = a_mag;
            rem_d     = 32'd0;
            neg_quo_d = sgn & (A[31] ^ B[31]);
            neg_rem_d = sgn & A[31];
            state_d   = StCalc;
          end
        end
      end
      StCalc: begin
        rem_d = ge ? diff : rem_sh[31:0];
        quo_d = {quo_q[30:0], ge};
        cnt_d = cnt_q - 5'd1;
        if (cnt_q == 5'd0) state_d = StFix;
      end
      StFix: begin
        if (is_rem_q) result_d = neg_rem_q ? (~rem_q + 32'd1) : rem_q;
        else          result_d = neg_quo_q ? (~quo_q + 32'd1) : quo_q;
        state_d = StDone;
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      is_rem_q  <= 1'b0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      quo_q     <= 32'd0;
      dvs_q     <= 32'd0;
      rem_q     <= 32'd0;
      cnt_q     <= 5'd0;
      result_q  <= 32'd0;
    end else begin
      state_q   <= state_d;
      is_rem_q  <= is_rem_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      quo_q     <= quo_d;
      dvs_q     <= dvs_d;
      rem_q     <= rem_d;
      cnt_q     <= cnt_d;
      result_q  <= result_d;
    end
  end

  assign busy   = (state_q != StIdle);
  assign done   = (state_q == StDone);
  assign result = result_q;

endmodule

// File: tb/tb_div_unit.sv
// Scoreboard bench for div_unit: the driver queues expected results and accept edges,
// a negedge monitor checks value and latency whenever done is presented.
module tb_div_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] A = 32'd0;
  logic [31:0] B = 32'd0;
  logic        busy, done;
  logic [31:0] result;

  div_unit dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .op     (op),
    .A      (A),
    .B      (B),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  always #5 clk = ~clk;

  localparam logic [1:0] OpDiv = 2'b00, OpDivu = 2'b01, OpRem = 2'b10, OpRemu = 2'b11;

  typedef struct {
    logic [31:0] r;
    int          k;
    int          lat;
  } exp_t;

  exp_t        sb[$];
  int          cyc = 0;
  int          passed = 0;
  int          total = 0;
  logic        prev_done = 1'b0;
  logic [31:0] last_res = 32'd0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act === req) passed++;
    else $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, cyc);
  endtask

  // Monitor: pops the scoreboard whenever done is high.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (done) begin
        if (prev_done) check("done_single_cycle", 32'd1, 32'd0);
        if (sb.size() == 0) begin
          check("unexpected_done", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          check("result", result, e.r);
          check("latency", cyc - e.k, e.lat);
          last_res = e.r;
        end
      end
      prev_done = done;
    end else begin
      prev_done = 1'b0;
    end
  end

  task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp_r, input int lat);
    @(posedge clk); #1;
    check("idle_before_issue", {31'd0, busy}, 32'd0);
    op = o; A = a; B = b; start = 1'b1;
    sb.push_back('{r: exp_r, k: cyc + 1, lat: lat});
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      check("drain_timeout", sb.size(), 32'd0);
      sb.delete();
    end
    repeat (3) @(posedge clk);
    #1;
    check("result_held", result, last_res);
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    int k;
    #2;
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_done", {31'd0, done}, 32'd0);
    check("reset_result", result, 32'd0);
    #20 rst_n = 1'b1;

    // Basic unsigned / signed / special-case vectors.
    issue(OpDivu, 32'd100, 32'd7, 32'd14, 33);                     drain();
    issue(OpRemu, 32'd100, 32'd7, 32'd2, 33);                      drain();
    issue(OpDiv, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33);         drain();
    issue(OpRem, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33);         drain();
    issue(OpDiv, 32'd1234, 32'd0, 32'hFFFF_FFFF, 1);               drain();
    issue(OpRemu, 32'd1234, 32'd0, 32'd1234, 1);                   drain();
    issue(OpDiv, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);  drain();
    issue(OpRem, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1);          drain();
    issue(OpDiv, 32'd20, 32'hFFFF_FFFA, 32'hFFFF_FFFD, 33);        drain();
    issue(OpRem, 32'd20, 32'hFFFF_FFFA, 32'd2, 33);                drain();
    issue(OpDivu, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 33);        drain();

    // Starts while busy are ignored.
    issue(OpDivu, 32'd100, 32'd7, 32'd14, 33);
    k = cyc - 1;
    wait_until(k + 4);
    op = OpDiv; A = 32'd999; B = 32'd3; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    check("busy_at_pulse5", {31'd0, busy}, 32'd1);
    wait_until(k + 19);
    op = OpRemu; A = 32'd55; B = 32'd0; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    check("busy_at_pulse20", {31'd0, busy}, 32'd1);
    drain();

    // Start held high: the next accept is one cycle after done (35-cycle period).
    @(posedge clk); #1;
    op = OpDivu; A = 32'd100; B = 32'd7; start = 1'b1;
    k = cyc + 1;
    sb.push_back('{r: 32'd14, k: k, lat: 33});
    sb.push_back('{r: 32'd14, k: k + 35, lat: 33});
    wait_until(k + 35);
    start = 1'b0;
    drain();

    // Same for the special path: 3-cycle period.
    @(posedge clk); #1;
    op = OpDiv; A = 32'd5; B = 32'd0; start = 1'b1;
    k = cyc + 1;
    sb.push_back('{r: 32'hFFFF_FFFF, k: k, lat: 1});
    sb.push_back('{r: 32'hFFFF_FFFF, k: k + 3, lat: 1});
    wait_until(k + 3);
    start = 1'b0;
    drain();

    // Asynchronous reset in the middle of CALC.
    issue(OpDivu, 32'd100, 32'd7, 32'd14, 33);
    k = cyc - 1;
    wait_until(k + 16);
    rst_n = 1'b0;
    #1;
    sb.delete();
    check("midreset_busy", {31'd0, busy}, 32'd0);
    check("midreset_done", {31'd0, done}, 32'd0);
    check("midreset_result", result, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    last_res = 32'd0;
    issue(OpDivu, 32'd50, 32'd5, 32'd10, 33);
    drain();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
